// File: rtl/sdf_stage_ctrl_if.sv
// rtl/sdf_stage_ctrl_if.sv - sample handshake and stage control bundle for sdf_stage_ctrl
interface sdf_stage_ctrl_if;
  logic in_valid;
  logic in_sop;
  logic flush;
  logic bf_sel;
  logic dl_shift;
  logic mul_j;
  logic out_valid;
  logic out_sop;
  logic flush_zero;
  logic busy;
  logic sop_err;

  modport master (
    output in_valid, in_sop, flush,
    input  bf_sel, dl_shift, mul_j, out_valid, out_sop, flush_zero, busy, sop_err
  );

  modport slave (
    input  in_valid, in_sop, flush,
    output bf_sel, dl_shift, mul_j, out_valid, out_sop, flush_zero, busy, sop_err
  );
endinterface

// File: rtl/sdf_stage_ctrl.sv
// rtl/sdf_stage_ctrl.sv - radix-2^2 SDF FFT stage sequencer; SDF_TRIVIAL_MUL_EN enables the -j select decode
module sdf_stage_ctrl #(
  parameter int LOG2_DELAY = 3,
  parameter int FRAME_LOG2 = 6
) (
  input logic            clk,
  input logic            rst_n,
  sdf_stage_ctrl_if.slave bus
);

  localparam int D = 1 << LOG2_DELAY;
  localparam logic [FRAME_LOG2-1:0] CNT_ONE  = FRAME_LOG2'(1);
  localparam logic [FRAME_LOG2-1:0] IDX_D    = FRAME_LOG2'(D);
  localparam logic [LOG2_DELAY-1:0] SUB_ONE  = LOG2_DELAY'(1);
  localparam logic [LOG2_DELAY-1:0] SUB_LAST = LOG2_DELAY'(D - 1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_FLUSH} state_t;

  state_t                  state_q, state_d;
  logic [FRAME_LOG2-1:0]   cnt_q, cnt_d;
  // Shared progress counter: samples buffered while filling, shift cycles while flushing.
  logic [LOG2_DELAY-1:0]   sub_q, sub_d;
  logic bf_sel_q, bf_sel_d;
  logic dl_shift_q, dl_shift_d;
  logic out_valid_q, out_valid_d;
  logic out_sop_q, out_sop_d;
  logic flush_zero_q, flush_zero_d;
  logic busy_q, busy_d;
  logic sop_err_q, sop_err_d;
  logic accept;
  logic [FRAME_LOG2-1:0]   idx;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sub_d        = sub_q;
    bf_sel_d     = 1'b0;
    dl_shift_d   = 1'b0;
    out_valid_d  = 1'b0;
    out_sop_d    = 1'b0;
    flush_zero_d = 1'b0;
    sop_err_d    = 1'b0;
    accept       = bus.in_valid && (state_q != S_FLUSH);
    idx          = (accept && bus.in_sop) ? '0 : cnt_q;

    if (accept) begin
      cnt_d       = idx + CNT_ONE;
      dl_shift_d  = 1'b1;
      bf_sel_d    = idx[LOG2_DELAY];
      out_valid_d = (state_q == S_RUN);
      out_sop_d   = (state_q == S_RUN) && (idx == IDX_D);
      sop_err_d   = bus.in_sop && (cnt_q != '0);
    end

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_FILL;
          sub_d   = SUB_ONE;
        end
      end
      S_FILL: begin
        if (accept) begin
          if (sub_q == SUB_LAST) begin
            state_d = S_RUN;
            sub_d   = '0;
          end else begin
            sub_d = sub_q + SUB_ONE;
          end
        end
      end
      S_RUN: begin
      end
      S_FLUSH: begin
        // Index keeps advancing so bf_sel tracks the zeros pushed through the delay line.
        dl_shift_d   = 1'b1;
        flush_zero_d = 1'b1;
        out_valid_d  = 1'b1;
        bf_sel_d     = cnt_q[LOG2_DELAY];
        cnt_d        = cnt_q + CNT_ONE;
        if (sub_q == SUB_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          sub_d   = '0;
        end else begin
          sub_d = sub_q + SUB_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (bus.flush && (state_q == S_FILL || state_q == S_RUN)) begin
      state_d = S_FLUSH;
      sub_d   = '0;
    end

    busy_d = (state_d != S_IDLE) || (state_q == S_FLUSH);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      sub_q        <= '0;
      bf_sel_q     <= 1'b0;
      dl_shift_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_sop_q    <= 1'b0;
      flush_zero_q <= 1'b0;
      busy_q       <= 1'b0;
      sop_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sub_q        <= sub_d;
      bf_sel_q     <= bf_sel_d;
      dl_shift_q   <= dl_shift_d;
      out_valid_q  <= out_valid_d;
      out_sop_q    <= out_sop_d;
      flush_zero_q <= flush_zero_d;
      busy_q       <= busy_d;
      sop_err_q    <= sop_err_d;
    end
  end

`ifdef SDF_TRIVIAL_MUL_EN
  logic mul_j_q, mul_j_d;

  always_comb begin
    mul_j_d = out_valid_d && (idx[LOG2_DELAY+1:LOG2_DELAY] == 2'b11);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mul_j_q <= 1'b0;
    end else begin
      mul_j_q <= mul_j_d;
    end
  end

  assign bus.mul_j = mul_j_q;
`else
  assign bus.mul_j = 1'b0;
`endif

  assign bus.bf_sel     = bf_sel_q;
  assign bus.dl_shift   = dl_shift_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_sop    = out_sop_q;
  assign bus.flush_zero = flush_zero_q;
  assign bus.busy       = busy_q;
  assign bus.sop_err    = sop_err_q;

endmodule

// File: tb/tb_sdf_stage_ctrl.sv
// tb/tb_sdf_stage_ctrl.sv - directed-vector bench for sdf_stage_ctrl (D=8, N=64)
module tb_sdf_stage_ctrl;

`ifdef SDF_TRIVIAL_MUL_EN
  localparam bit MULJ = 1'b1;
`else
  localparam bit MULJ = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  sdf_stage_ctrl_if bus ();

  sdf_stage_ctrl #(.LOG2_DELAY(3), .FRAME_LOG2(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Output vector order: {bf_sel, dl_shift, mul_j, out_valid, out_sop, flush_zero, busy, sop_err}
  function automatic logic [7:0] outs();
    return {bus.bf_sel, bus.dl_shift, bus.mul_j, bus.out_valid,
            bus.out_sop, bus.flush_zero, bus.busy, bus.sop_err};
  endfunction

  function automatic logic [7:0] exp_smp(input int idx, input bit ov, input bit se);
    logic bf;
    logic mj;
    logic osop;
    bf   = ((idx >> 3) & 1) == 1;
    mj   = MULJ && ov && (((idx >> 3) & 3) == 3);
    osop = ov && (idx == 8);
    return {bf, 1'b1, mj, ov, osop, 1'b0, 1'b1, se};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic v, input logic s, input logic f);
    @(negedge clk);
    bus.in_valid = v;
    bus.in_sop   = s;
    bus.flush    = f;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int idx;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_sop   = 1'b0;
    bus.flush    = 1'b0;

    // Reset for 3 cycles, with stimulus present to prove it is ignored
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0);
      check($sformatf("reset_%0d", i), 32'(outs()), 32'h0);
    end
    rst_n = 1'b1;

    // Steady frame: sop + 64 continuous samples
    for (int i = 0; i < 64; i++) begin
      step(1'b1, i == 0, 1'b0);
      check($sformatf("steady_idx%0d", i), 32'(outs()), 32'(exp_smp(i, i >= 8, 1'b0)));
    end

    // Gapped: 1-on/1-off, 32 accepted samples
    for (int k = 0; k < 64; k++) begin
      if (k % 2 == 0) begin
        step(1'b1, 1'b0, 1'b0);
        check($sformatf("gap_idx%0d", k / 2), 32'(outs()), 32'(exp_smp(k / 2, 1'b1, 1'b0)));
      end else begin
        step(1'b0, 1'b0, 1'b0);
        check($sformatf("gap_hole%0d", k / 2), 32'(outs()), 32'h02);
      end
    end

    // Finish the frame and run to index 19 of the next one
    for (int k = 0; k < 52; k++) begin
      idx = (32 + k) % 64;
      step(1'b1, 1'b0, 1'b0);
      check($sformatf("pre_sop_idx%0d", idx), 32'(outs()), 32'(exp_smp(idx, 1'b1, 1'b0)));
    end

    // Misaligned sop at index 20 becomes index 0
    step(1'b1, 1'b1, 1'b0);
    check("misaligned_sop", 32'(outs()), 32'(exp_smp(0, 1'b1, 1'b1)));
    for (int i = 1; i < 13; i++) begin
      step(1'b1, 1'b0, 1'b0);
      check($sformatf("realign_idx%0d", i), 32'(outs()), 32'(exp_smp(i, 1'b1, 1'b0)));
    end

    // Flush requested together with index 13
    step(1'b1, 1'b0, 1'b1);
    check("flush_last_sample", 32'(outs()), 32'(exp_smp(13, 1'b1, 1'b0)));
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 1'b0);
      check($sformatf("flush_cyc%0d", i), 32'(outs() & 8'b0101_1111), 32'h56);
    end
    step(1'b0, 1'b0, 1'b0);
    check("flush_done", 32'(outs()), 32'h0);

    // Back from IDLE with cleared count, run to index 40
    for (int i = 0; i <= 40; i++) begin
      step(1'b1, 1'b0, 1'b0);
      check($sformatf("refill_idx%0d", i), 32'(outs()), 32'(exp_smp(i, i >= 8, 1'b0)));
    end

    // One-cycle reset mid-frame
    rst_n = 1'b0;
    step(1'b1, 1'b0, 1'b0);
    check("midreset", 32'(outs()), 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, i == 0, 1'b0);
      check($sformatf("post_reset_idx%0d", i), 32'(outs()), 32'(exp_smp(i, i >= 8, 1'b0)));
    end

    // Flush in IDLE is ignored
    rst_n = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b1);
    check("idle_flush_a", 32'(outs()), 32'h0);
    step(1'b0, 1'b0, 1'b0);
    check("idle_flush_b", 32'(outs()), 32'h0);
    step(1'b1, 1'b0, 1'b0);
    check("idle_flush_fill", 32'(outs()), 32'(exp_smp(0, 1'b0, 1'b0)));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
